// File: rtl/wt_dcache_ship_ctrl.sv
// SHiP/RRIP replacement controller for the write-through dcache.
// Keeps per-line signature/outcome/RRPV, picks miss victims and feeds update pulses to the SHCT predictor.
module wt_dcache_ship_ctrl #(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned NumWays  = 8,
    parameter int unsigned SigWidth = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       access_valid_i,
    output logic                       ready_o,
    input  logic                       access_hit_i,
    input  logic [$clog2(NumSets)-1:0] access_set_i,
    input  logic [$clog2(NumWays)-1:0] access_way_i,
    input  logic [SigWidth-1:0]        access_sig_i,
    output logic                       victim_valid_o,
    output logic [$clog2(NumWays)-1:0] victim_way_o,
    output logic                       pred_hit_o,
    output logic [SigWidth-1:0]        pred_hit_shct_o,
    output logic                       pred_miss_o,
    output logic                       pred_outcome_o,
    output logic [SigWidth-1:0]        pred_miss_shct_o,
    output logic [SigWidth-1:0]        pred_shct_o,
    input  logic                       pred_result_i
);

    localparam int unsigned IdxW = $clog2(NumSets);
    localparam int unsigned WayW = $clog2(NumWays);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSearch  = 2'd1;
    localparam logic [1:0] StInstall = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IdxW-1:0]     set_q, set_d;
    logic [SigWidth-1:0] cap_sig_q, cap_sig_d;
    logic [WayW-1:0]     victim_q, victim_d;

    logic [NumWays-1:0]  valid_q   [NumSets];
    logic [NumWays-1:0]  valid_d   [NumSets];
    logic [NumWays-1:0]  outcome_q [NumSets];
    logic [NumWays-1:0]  outcome_d [NumSets];
    logic [SigWidth-1:0] sig_q     [NumSets][NumWays];
    logic [SigWidth-1:0] sig_d     [NumSets][NumWays];
    logic [1:0]          rrpv_q    [NumSets][NumWays];
    logic [1:0]          rrpv_d    [NumSets][NumWays];

    logic            inv_found, dist_found;
    logic [WayW-1:0] inv_way, dist_way;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        inv_found  = 1'b0;
        dist_found = 1'b0;
        inv_way    = '0;
        dist_way   = '0;
        for (int w = NumWays - 1; w >= 0; w--) begin
            if (!valid_q[set_q][w]) begin
                inv_found = 1'b1;
                inv_way   = WayW'(w);
            end
            if (rrpv_q[set_q][w] == 2'd3) begin
                dist_found = 1'b1;
                dist_way   = WayW'(w);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        cap_sig_d = cap_sig_q;
        victim_d  = victim_q;
        valid_d   = valid_q;
        outcome_d = outcome_q;
        sig_d     = sig_q;
        rrpv_d    = rrpv_q;

        ready_o          = (state_q == StIdle);
        victim_valid_o   = 1'b0;
        victim_way_o     = '0;
        pred_hit_o       = 1'b0;
        pred_hit_shct_o  = '0;
        pred_miss_o      = 1'b0;
        pred_outcome_o   = 1'b1;
        pred_miss_shct_o = '0;
        pred_shct_o      = (state_q == StIdle) ? access_sig_i : cap_sig_q;

        case (state_q)
            StIdle: begin
                if (access_valid_i) begin
                    if (access_hit_i) begin
                        // A hit on an invalid way is ignored: no pulse, no update.
                        if (valid_q[access_set_i][access_way_i]) begin
                            pred_hit_o      = 1'b1;
                            pred_hit_shct_o = sig_q[access_set_i][access_way_i];
                            outcome_d[access_set_i][access_way_i] = 1'b1;
                            rrpv_d[access_set_i][access_way_i]    = 2'd0;
                        end
                    end else begin
                        set_d     = access_set_i;
                        cap_sig_d = access_sig_i;
                        state_d   = StSearch;
                    end
                end
            end
            StSearch: begin
                if (inv_found) begin
                    victim_d = inv_way;
                    state_d  = StInstall;
                end else if (dist_found) begin
                    victim_d = dist_way;
                    state_d  = StInstall;
                end else begin
                    for (int w = 0; w < NumWays; w++) begin
                        if (rrpv_q[set_q][w] != 2'd3) begin
                            rrpv_d[set_q][w] = rrpv_q[set_q][w] + 2'd1;
                        end
                    end
                end
            end
            StInstall: begin
                victim_valid_o   = 1'b1;
                victim_way_o     = victim_q;
                pred_miss_o      = 1'b1;
                pred_miss_shct_o = sig_q[set_q][victim_q];
                pred_outcome_o   = valid_q[set_q][victim_q] ? outcome_q[set_q][victim_q] : 1'b1;
                valid_d[set_q][victim_q]   = 1'b1;
                sig_d[set_q][victim_q]     = cap_sig_q;
                outcome_d[set_q][victim_q] = 1'b0;
                rrpv_d[set_q][victim_q]    = pred_result_i ? 2'd2 : 2'd3;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d          = StIdle;
            victim_valid_o   = 1'b0;
            victim_way_o     = '0;
            pred_hit_o       = 1'b0;
            pred_hit_shct_o  = '0;
            pred_miss_o      = 1'b0;
            pred_outcome_o   = 1'b1;
            pred_miss_shct_o = '0;
            for (int s = 0; s < NumSets; s++) begin
                valid_d[s]   = '0;
                outcome_d[s] = '0;
                for (int w = 0; w < NumWays; w++) begin
                    sig_d[s][w]  = '0;
                    rrpv_d[s][w] = 2'd3;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            set_q     <= '0;
            cap_sig_q <= '0;
            victim_q  <= '0;
            for (int s = 0; s < NumSets; s++) begin
                valid_q[s]   <= '0;
                outcome_q[s] <= '0;
                for (int w = 0; w < NumWays; w++) begin
                    sig_q[s][w]  <= '0;
                    rrpv_q[s][w] <= 2'd3;
                end
            end
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            cap_sig_q <= cap_sig_d;
            victim_q  <= victim_d;
            valid_q   <= valid_d;
            outcome_q <= outcome_d;
            sig_q     <= sig_d;
            rrpv_q    <= rrpv_d;
        end
    end

endmodule
